arbiter_8x3: RTL and testbench

Round-robin arbiter that shares one downstream resource between 8 requesters. Its grant is one-hot, with a 3-bit binary index derived from it by one-hot-to-binary encoding. It holds each grant until the requester releases it, or until a programmable hold timeout expires. It sits in front of any shared datapath that needs exactly one owner per cycle and an encoded owner index.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/onehot_enc8.sv | 19 +
 rtl/arbiter_8x3.sv | 100 ++++++++++
 tb/tb_arbiter_8x3.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } state_e;

    // Rotate-and-find-first: search upward from (last + 1), wrapping past 7 to 0.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [N_REQ-1:0] pick;
        logic             found;
        logic [IDX_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            // IDX_W-bit addition wraps modulo N_REQ for free.
            idx = last + IDX_W'(k);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot_enc8.sv
// Combinational 8-to-3 one-hot-to-binary encoder; all-zero input encodes to 0.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // OR together the indices of set bits; exact for one-hot input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with one-hot grant, encoded index and hold timeout.
module arbiter_8x3
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    // Final count value at which an owner that still requests is revoked.
    localparam logic [7:0] HoldLast = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;

    // Next-state logic for the FSM, grant, hold counter and last owner.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d      = rr_pick(req, last_q);
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = 8'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q]) begin
                    // Release wins over a coincident timeout.
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    last_d    = gnt_idx_q;
                    state_d   = IDLE;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HoldLast)) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    last_d    = gnt_idx_q;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    onehot_enc8 u_enc (
        .onehot (gnt_d),
        .idx    (gnt_idx_d)
    );

    // State and registered outputs; reset gives requester 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
            last_q     <= IDX_W'(N_REQ - 1);
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_8x3.sv
// Scoreboard bench for arbiter_8x3 against a behavioural round-robin model.
module tb_arbiter_8x3;

    localparam int unsigned MaxHold = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    exp_t pending;
    bit   have_pending = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state: current owner (-1 = none), last owner, cycles owned so far.
    int m_owner = -1;
    int m_last  = 7;
    int m_held  = 0;

    arbiter_8x3 #(
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome of one clock edge given the request vector seen at that edge.
    task automatic model_edge(input logic [7:0] r, output exp_t e);
        bit to;
        int c;
        to = 1'b0;
        if (m_owner < 0) begin
            if (r != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    c = (m_last + k) % 8;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_held = 0;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            m_held++;
            if (MaxHold != 0 && m_held == int'(MaxHold)) begin
                m_last  = m_owner;
                m_owner = -1;
                to      = 1'b1;
            end
        end
        e.gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.vld = (m_owner >= 0);
        e.to  = to;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_held  = 0;
    endtask

    // Publish the expectation for the edge just passed, then drive the next request.
    task automatic step(input logic [7:0] r);
        @(posedge clk);
        #1;
        if (have_pending) exp_q.push_back(pending);
        req = r;
        model_edge(r, pending);
        have_pending = 1'b1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_idx"}, 32'(gnt_idx), 32'h0);
        check({tag, "_vld"}, 32'(gnt_vld), 32'h0);
        check({tag, "_to"}, 32'(timeout), 32'h0);
    endtask

    // Async reset pulse between edges; outputs must clear without waiting for a clock.
    task automatic reset_now(input logic [7:0] next_req);
        #2;
        exp_q.delete();
        have_pending = 1'b0;
        rst = 1'b1;
        #1;
        check_cleared("async_rst");
        rst = 1'b0;
        model_reset();
        req = next_req;
        model_edge(next_req, pending);
        have_pending = 1'b1;
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            check("gnt_vld", 32'(gnt_vld), 32'(e.vld));
            check("timeout", 32'(timeout), 32'(e.to));
        end
    end

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        req = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        #2;
        rst = 1'b0;
        model_reset();
        model_edge(req, pending);
        have_pending = 1'b1;

        // First grant after reset goes to requester 0, then release.
        step(8'h00);
        step(8'h00);

        // Single requester 3: grant, hold, release without timeout.
        step(8'h08);
        repeat (3) step(8'h08);
        step(8'h00);
        step(8'h00);

        // Round-robin: everyone requests, each owner releases after one cycle.
        for (int g = 0; g < 9; g++) begin
            step(8'hFF);
            step(8'hFF ^ 8'(1 << m_owner));
        end
        step(8'h00);
        step(8'h00);

        // Timeout: requesters 0 and 5 hold their requests high.
        repeat (16) step(8'h21);
        step(8'h00);
        step(8'h00);

        // Owner drops its request on the edge the timeout would fire.
        step(8'h01);
        repeat (3) step(8'h01);
        step(8'h00);
        step(8'h00);

        // Reset in the middle of a grant to requester 6.
        step(8'h40);
        step(8'h40);
        reset_now(8'h41);
        repeat (3) step(8'h41);
        step(8'h00);

        // Randomised traffic, biased so owners usually keep requesting.
        for (int n = 0; n < 400; n++) begin
            r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            step(r);
        end
        step(8'h00);
        step(8'h00);

        @(posedge clk);
        #1;
        if (have_pending) exp_q.push_back(pending);
        have_pending = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
